// File: rtl/operand_fetch_pkg.sv
// Shared sizes, ALU opcode encoding and pipeline-stage record for the operand fetch stage.
package operand_fetch_pkg;

   localparam int WORD_SIZE     = 16;
   localparam int REG_COUNT     = 8;
   localparam int REG_ADDR_BITS = 3;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLL = 3'd5,
      ALU_SRL = 3'd6,
      ALU_SLT = 3'd7
   } alu_op_e;

   typedef struct packed {
      logic                     vld;
      logic [REG_ADDR_BITS-1:0] rd;
   } stage_t;

endpackage

// File: rtl/operand_fetch_regfile.sv
// Eight-entry register file: two combinational read ports, one synchronous write port, r0 reads zero.
module operand_fetch_regfile
   import operand_fetch_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [REG_ADDR_BITS-1:0] waddr,
   input  logic [WORD_SIZE-1:0]     wdata,
   input  logic [REG_ADDR_BITS-1:0] raddr1,
   input  logic [REG_ADDR_BITS-1:0] raddr2,
   output logic [WORD_SIZE-1:0]     rdata1,
   output logic [WORD_SIZE-1:0]     rdata2
);

   logic [WORD_SIZE-1:0] regs [REG_COUNT];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: hazard stall, writeback bypass and S1/S2 tracking around an external registered ALU.
module operand_fetch
   import operand_fetch_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  alu_op_e                  in_op,
   input  logic [REG_ADDR_BITS-1:0] in_rd,
   input  logic [REG_ADDR_BITS-1:0] in_rs1,
   input  logic [REG_ADDR_BITS-1:0] in_rs2,
   input  logic                     in_use_imm,
   input  logic [WORD_SIZE-1:0]     in_imm,
   output alu_op_e                  alu_op,
   output logic [WORD_SIZE-1:0]     alu_in1,
   output logic [WORD_SIZE-1:0]     alu_in2,
   input  logic [WORD_SIZE-1:0]     alu_result,
   output logic                     wb_valid,
   output logic [REG_ADDR_BITS-1:0] wb_rd,
   output logic [WORD_SIZE-1:0]     wb_data
);

   stage_t               s1, s2;
   logic [WORD_SIZE-1:0] rf_data1, rf_data2;
   logic [WORD_SIZE-1:0] op1, op2;
   logic                 hazard, accept;

   // The result in S2 is already on alu_result, so it wins over the not-yet-written regfile entry.
   function automatic logic [WORD_SIZE-1:0] operand_value(
      input logic [REG_ADDR_BITS-1:0] rs,
      input logic [WORD_SIZE-1:0]     rf_value,
      input stage_t                   wb_stage,
      input logic [WORD_SIZE-1:0]     bypass_value
   );
      if (rs == '0)                            return '0;
      else if (wb_stage.vld && wb_stage.rd == rs) return bypass_value;
      else                                     return rf_value;
   endfunction

   operand_fetch_regfile u_regfile (
      .clk    (clk),
      .reset  (reset),
      .we     (wb_valid),
      .waddr  (wb_rd),
      .wdata  (wb_data),
      .raddr1 (in_rs1),
      .raddr2 (in_rs2),
      .rdata1 (rf_data1),
      .rdata2 (rf_data2)
   );

   // S1's result does not exist until the ALU registers it, so a read of its rd must wait one cycle.
   assign hazard   = s1.vld && (s1.rd != '0) &&
                     ((in_rs1 == s1.rd) || (!in_use_imm && (in_rs2 == s1.rd)));
   assign in_ready = !hazard;
   assign accept   = in_valid && in_ready;

   assign op1 = operand_value(in_rs1, rf_data1, s2, alu_result);
   assign op2 = in_use_imm ? in_imm : operand_value(in_rs2, rf_data2, s2, alu_result);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1      <= '0;
         s2      <= '0;
         alu_op  <= ALU_ADD;
         alu_in1 <= '0;
         alu_in2 <= '0;
      end else begin
         s2 <= s1;
         if (accept) begin
            s1      <= '{vld: 1'b1, rd: in_rd};
            alu_op  <= in_op;
            alu_in1 <= op1;
            alu_in2 <= op2;
         end else begin
            s1      <= '0;
            alu_op  <= ALU_ADD;
            alu_in1 <= '0;
            alu_in2 <= '0;
         end
      end
   end

   assign wb_valid = s2.vld && (s2.rd != '0);
   assign wb_rd    = s2.rd;
   assign wb_data  = alu_result;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch paired with a behavioural registered ALU; architectural in-order reference model.
module tb_operand_fetch;
   import operand_fetch_pkg::*;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   alu_op_e              in_op;
   logic [2:0]           in_rd, in_rs1, in_rs2;
   logic                 in_use_imm;
   logic [15:0]          in_imm;
   alu_op_e              alu_op;
   logic [15:0]          alu_in1, alu_in2;
   logic [15:0]          alu_result;
   logic                 wb_valid;
   logic [2:0]           wb_rd;
   logic [15:0]          wb_data;

   int checks = 0;
   int errors = 0;

   // Architectural state: every accepted instruction sees all earlier results.
   logic [15:0] mregs [8];
   bit          last_acc;
   logic [2:0]  last_rd;
   bit          pend_v;
   logic [2:0]  pend_rd;
   logic [15:0] pend_d;

   operand_fetch dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_use_imm (in_use_imm),
      .in_imm     (in_imm),
      .alu_op     (alu_op),
      .alu_in1    (alu_in1),
      .alu_in2    (alu_in2),
      .alu_result (alu_result),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] alu_fn(input alu_op_e op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         ALU_SLL: return a << b[3:0];
         ALU_SRL: return a >> b[3:0];
         default: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) alu_result <= '0;
      else       alu_result <= alu_fn(alu_op, alu_in1, alu_in2);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 8; i++) mregs[i] = '0;
      last_acc = 0;
      last_rd  = '0;
      pend_v   = 0;
      pend_rd  = '0;
      pend_d   = '0;
   endtask

   // One clock: check ready before the edge, update the model, check outputs after the edge.
   task automatic do_cycle(output bit acc);
      bit          exp_rdy;
      logic [15:0] a, b, r;
      alu_op_e     eop;
      bit          nv;
      logic [2:0]  nrd;
      #1;
      exp_rdy = !(last_acc && last_rd != 3'd0 &&
                  (in_rs1 == last_rd || (!in_use_imm && in_rs2 == last_rd)));
      chk("in_ready", in_ready, exp_rdy);
      acc = in_valid && in_ready;
      eop = ALU_ADD; a = '0; b = '0; r = '0;
      if (acc) begin
         eop = in_op;
         a   = mregs[in_rs1];
         b   = in_use_imm ? in_imm : mregs[in_rs2];
         r   = alu_fn(eop, a, b);
         if (in_rd != 3'd0) mregs[in_rd] = r;
      end
      nv  = acc && (in_rd != 3'd0);
      nrd = in_rd;
      @(posedge clk);
      #1;
      chk("alu_op", alu_op, eop);
      chk("alu_in1", alu_in1, a);
      chk("alu_in2", alu_in2, b);
      chk("wb_valid", wb_valid, pend_v);
      if (pend_v) begin
         chk("wb_rd", wb_rd, pend_rd);
         chk("wb_data", wb_data, pend_d);
      end
      pend_v   = nv;
      pend_rd  = nrd;
      pend_d   = r;
      last_acc = acc;
      last_rd  = nrd;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bit acc;
      in_valid = 0;
      for (int i = 0; i < n; i++) do_cycle(acc);
   endtask

   task automatic issue(input alu_op_e op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input bit ui, input logic [15:0] imm,
                        output int stalls);
      bit acc;
      in_valid = 1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_use_imm = ui; in_imm = imm;
      stalls = 0;
      acc = 0;
      for (int k = 0; k < 3; k++) begin
         do_cycle(acc);
         if (acc) break;
         stalls++;
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
      chk("max_stall", (stalls <= 1) ? 32'd1 : 32'd0, 32'd1);
      in_valid = 0;
   endtask

   // Reset applied mid-cycle; outputs must clear without waiting for a clock edge.
   task automatic pulse_reset();
      reset = 1;
      #1;
      chk("rst_alu_op", alu_op, ALU_ADD);
      chk("rst_alu_in1", alu_in1, 16'd0);
      chk("rst_alu_in2", alu_in2, 16'd0);
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_wb_rd", wb_rd, 3'd0);
      chk("rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      chk("rst_hold_wb_valid", wb_valid, 1'b0);
      @(negedge clk);
      reset = 0;
      clear_model();
   endtask

   initial begin
      int st;
      bit acc;
      reset = 1; in_valid = 0; in_op = ALU_ADD; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
      in_use_imm = 0; in_imm = 0;
      clear_model();
      @(negedge clk);
      pulse_reset();

      // r1 = r0 + 5
      issue(ALU_ADD, 3'd1, 3'd0, 3'd0, 1, 16'd5, st);
      chk("s34_stall", st, 0);
      idle(3);

      // r1 = 5, then dependent r2 = r1 - 2 must stall once and use the bypass
      issue(ALU_ADD, 3'd1, 3'd0, 3'd0, 1, 16'd5, st);
      issue(ALU_SUB, 3'd2, 3'd1, 3'd0, 1, 16'd2, st);
      chk("s35_stall", st, 1);
      idle(3);

      // r3 = 7, r4 = 1, r5 = r3 + r3 with no stall
      issue(ALU_ADD, 3'd3, 3'd0, 3'd0, 1, 16'd7, st);
      issue(ALU_ADD, 3'd4, 3'd0, 3'd0, 1, 16'd1, st);
      issue(ALU_ADD, 3'd5, 3'd3, 3'd3, 0, 16'd0, st);
      chk("s36_stall", st, 0);
      idle(3);

      // write to r0 discarded, dependent read of r0 never stalls
      issue(ALU_ADD, 3'd0, 3'd0, 3'd0, 1, 16'd9, st);
      issue(ALU_ADD, 3'd6, 3'd0, 3'd0, 1, 16'd0, st);
      chk("s37_stall", st, 0);
      idle(3);

      // r7 = 3 killed by reset before writeback
      issue(ALU_ADD, 3'd7, 3'd0, 3'd0, 1, 16'd3, st);
      pulse_reset();
      idle(2);
      issue(ALU_OR, 3'd1, 3'd7, 3'd7, 0, 16'd0, st);
      idle(3);

      // randomized traffic with occasional mid-run reset
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            pulse_reset();
         end else if ($urandom_range(0, 3) == 0) begin
            in_valid = 0;
            in_rs1 = 3'($urandom_range(0, 7));
            in_rs2 = 3'($urandom_range(0, 7));
            in_use_imm = 1'($urandom_range(0, 1));
            do_cycle(acc);
         end else begin
            issue(alu_op_e'(3'($urandom_range(0, 7))), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 16'($urandom), st);
         end
      end
      idle(3);

      // read back every register through the operand path
      for (int i = 1; i < 8; i++) issue(ALU_ADD, 3'd0, 3'(i), 3'd0, 1, 16'd0, st);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
